// File: rtl/phase_fifo_drain_arbiter_pkg.sv
// ============================================================================
// Module : phase_pkg
// Brief  : Shared types and the rotate-priority helper for the drain arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package phase_pkg;

  localparam int WORD_COUNT_W = 16;
  localparam int RR_MAX_CH    = 16;
  localparam int RR_IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of mask at or above ptr, wrapping at n; ptr must be < n.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_CH-1:0] mask,
    input logic [RR_IDX_W-1:0]  ptr,
    input int                   n
  );
    rr_pick_t r;
    int       c;
    r = '0;
    for (int i = 0; i < RR_MAX_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= n) c = c - n;
      if (!r.found && (i < n) && mask[c[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_fifo_drain_arbiter_rr_priority_pick.sv
// ============================================================================
// Module : rr_priority_pick
// Brief  : Combinational rotate-priority encoder (mask, ptr -> idx, found).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
  import phase_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_found
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick  = rr_pick(RR_MAX_CH'(i_mask), RR_IDX_W'(i_ptr), NUM_CH);
    o_idx   = w_pick.idx[IDX_W-1:0];
    o_found = w_pick.found;
  end

endmodule

`default_nettype wire

// File: rtl/phase_fifo_drain_arbiter.sv
// ============================================================================
// Module : phase_fifo_drain_arbiter
// Brief  : Round-robin burst-limited reader of NUM_CH phase-tag FIFOs onto
//          one {channel, tag} valid/ready stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_fifo_drain_arbiter
  import phase_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_MAX  = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         RdClk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic [NUM_CH-1:0]            i_fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_fifo_q,
  output logic [NUM_CH-1:0]            o_fifo_rd_en,
  output logic [CH_W+DATA_WIDTH-1:0]   o_out_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [CH_W-1:0]              o_active_ch,
  output logic                         o_busy,
  output logic [WORD_COUNT_W-1:0]      o_word_count
);

  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_t                 r_state;
  arb_state_t                 w_state_nxt;
  logic [CH_W-1:0]            r_cur_ch;
  logic [CH_W-1:0]            r_active_ch;
  logic [CH_W-1:0]            r_rr_ptr;
  logic [BW-1:0]              r_burst_cnt;
  logic [CH_W+DATA_WIDTH-1:0] r_out_data;
  logic                       r_out_valid;
  logic                       r_busy;
  logic [WORD_COUNT_W-1:0]    r_word_count;

  logic [CH_W-1:0]            w_pick_idx;
  logic                       w_pick_found;
  logic                       w_grant;
  logic                       w_rd_ok;
  logic                       w_continue;
  logic [CH_W-1:0]            w_next_ptr;
  logic [DATA_WIDTH-1:0]      w_q_slice;
  logic [NUM_CH-1:0]          w_rd_en;

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_pick (
    .i_mask  (~i_fifo_empty),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_grant    = i_enable && w_pick_found;
  assign w_rd_ok    = ~i_fifo_empty[r_cur_ch];
  assign w_q_slice  = i_fifo_q[r_cur_ch * DATA_WIDTH +: DATA_WIDTH];
  assign w_continue = ((int'(r_burst_cnt) + 1) < BURST_MAX) && i_enable && w_rd_ok;
  // Explicit wrap keeps ids below NUM_CH when it is not a power of two.
  assign w_next_ptr = (r_cur_ch == CH_W'(NUM_CH - 1)) ? '0 : r_cur_ch + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = '0;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = READ;
      READ: begin
        if (w_rd_ok) begin
          w_rd_en[r_cur_ch] = 1'b1;
          w_state_nxt       = CAPT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAPT: w_state_nxt = SEND;
      SEND: if (i_out_ready) w_state_nxt = w_continue ? READ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge RdClk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cur_ch     <= '0;
      r_active_ch  <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cur_ch    <= w_pick_idx;
            r_active_ch <= w_pick_idx;
            r_burst_cnt <= '0;
          end
        end
        CAPT: begin
          r_out_data  <= {r_cur_ch, w_q_slice};
          r_out_valid <= 1'b1;
        end
        SEND: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (r_word_count != '1) r_word_count <= r_word_count + 1'b1;
            if (!w_continue) r_rr_ptr <= w_next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_rd_en = w_rd_en;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_active_ch  = r_active_ch;
  assign o_busy       = r_busy;
  assign o_word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_phase_fifo_drain_arbiter.sv
// ============================================================================
// Module : tb_phase_fifo_drain_arbiter
// Brief  : Directed-vector bench with behavioural one-cycle-latency FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phase_fifo_drain_arbiter;

  logic        RdClk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_q = '0;
  logic [3:0]  fifo_rd_en;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  active_ch;
  logic        busy;
  logic [15:0] word_count;

  always #5 RdClk = ~RdClk;

  phase_fifo_drain_arbiter #(
    .NUM_CH     (4),
    .DATA_WIDTH (8),
    .BURST_MAX  (4)
  ) dut (
    .RdClk        (RdClk),
    .rst          (rst),
    .i_enable     (enable),
    .i_fifo_empty (fifo_empty),
    .i_fifo_q     (fifo_q),
    .o_fifo_rd_en (fifo_rd_en),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_active_ch  (active_ch),
    .o_busy       (busy),
    .o_word_count (word_count)
  );

  logic [7:0] mem [4][64];
  int         wp [4];
  int         rp [4];
  int         rd_cnt [4];
  int         viol = 0;
  logic [9:0] q_log [$];
  int         n_acc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      rd_cnt[i] = 0;
    end
  end

  always @* begin
    for (int i = 0; i < 4; i++) fifo_empty[i] = (wp[i] == rp[i]);
  end

  always @(posedge RdClk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd_en[i]) begin
        if (fifo_empty[i]) viol <= viol + 1;
        fifo_q[i*8 +: 8] <= mem[i][rp[i] % 64];
        rp[i]            <= rp[i] + 1;
        rd_cnt[i]        <= rd_cnt[i] + 1;
      end
    end
    if (!rst && out_valid && out_ready) begin
      q_log.push_back(out_data);
      n_acc <= n_acc + 1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge RdClk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    mem[ch][wp[ch] % 64] = d;
    wp[ch] = wp[ch] + 1;
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int k = 0;
    while (n_acc < target && k < budget) begin
      tick(1);
      k++;
    end
    check_vec(tag, 32'(n_acc), 32'(target));
  endtask

  initial begin
    int base;
    int rd_base;
    int k;
    logic stable;

    // Reset values
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    check_vec("rst_valid", 32'(out_valid), 32'd0);
    check_vec("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_vec("rst_wcnt", 32'(word_count), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_data", 32'(out_data), 32'd0);
    check_vec("rst_active", 32'(active_ch), 32'd0);

    // Single channel, latency and rotation pointer
    push(2, 8'h11); push(2, 8'h22);
    tick(1);
    check_vec("t1_rd0", 32'(fifo_rd_en), 32'h4);
    check_vec("t1_active", 32'(active_ch), 32'd2);
    check_vec("t1_busy", 32'(busy), 32'd1);
    tick(1);
    check_vec("t1_nv", 32'(out_valid), 32'd0);
    tick(1);
    check_vec("t1_v0", 32'(out_valid), 32'd1);
    check_vec("t1_d0", 32'(out_data), 32'h211);
    tick(1);
    check_vec("t1_rd1", 32'(fifo_rd_en), 32'h4);
    tick(2);
    check_vec("t1_d1", 32'(out_data), 32'h222);
    tick(1);
    check_vec("t1_idle", 32'(busy), 32'd0);
    check_vec("t1_wcnt", 32'(word_count), 32'd2);
    check_vec("t1_ptr", 32'(dut.r_rr_ptr), 32'd3);
    check_vec("t1_rdcnt", 32'(rd_cnt[2]), 32'd2);

    // Fairness across four full FIFOs
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 10; j++) push(c, 8'(c * 16 + j));
    base = n_acc;
    wait_acc("fair_cnt", base + 40, 300);
    k = base;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < ((r < 2) ? 4 : 2); j++) begin
          check_vec("fair_word", 32'(q_log[k]), 32'({2'(c), 8'(c * 16 + r * 4 + j)}));
          k++;
        end

    // Backpressure in SEND
    tick(2);
    out_ready = 1'b0;
    push(0, 8'hA0); push(0, 8'hA1);
    base = n_acc;
    k = 0;
    while (!out_valid && k < 10) begin tick(1); k++; end
    check_vec("bp_valid", 32'(out_valid), 32'd1);
    rd_base = rd_cnt[0];
    stable = 1'b1;
    repeat (20) begin
      tick(1);
      if (!(out_valid && out_data == 10'h0A0)) stable = 1'b0;
    end
    check_vec("bp_stable", 32'(stable), 32'd1);
    check_vec("bp_no_rd", 32'(rd_cnt[0]), 32'(rd_base));
    out_ready = 1'b1;
    tick(1);
    check_vec("bp_once", 32'(n_acc), 32'(base + 1));
    check_vec("bp_drop", 32'(out_valid), 32'd0);
    wait_acc("bp_cnt", base + 2, 20);
    check_vec("bp_w0", 32'(q_log[base]), 32'h0A0);
    check_vec("bp_w1", 32'(q_log[base + 1]), 32'h0A1);

    // Enable drop after second handshake of a burst
    tick(2);
    for (int j = 0; j < 5; j++) push(1, 8'(8'h50 + j));
    base = n_acc;
    rd_base = rd_cnt[1];
    wait_acc("en_two", base + 2, 30);
    enable = 1'b0;
    tick(30);
    check_vec("en_cnt", 32'(n_acc), 32'(base + 3));
    check_vec("en_w2", 32'(q_log[base + 2]), 32'h152);
    check_vec("en_rds", 32'(rd_cnt[1] - rd_base), 32'd3);
    check_vec("en_busy", 32'(busy), 32'd0);
    check_vec("en_ptr", 32'(dut.r_rr_ptr), 32'd2);

    // Reset while in CAPT
    enable = 1'b1;
    k = 0;
    while (fifo_rd_en == 4'd0 && k < 5) begin tick(1); k++; end
    check_vec("rc_rd", 32'(fifo_rd_en), 32'h2);
    tick(1);
    rst = 1'b1;
    tick(1);
    check_vec("rc_valid", 32'(out_valid), 32'd0);
    check_vec("rc_rd_en", 32'(fifo_rd_en), 32'd0);
    check_vec("rc_wcnt", 32'(word_count), 32'd0);
    check_vec("rc_busy", 32'(busy), 32'd0);
    check_vec("rc_ptr", 32'(dut.r_rr_ptr), 32'd0);
    rst = 1'b0;
    base = n_acc;
    wait_acc("rc_drain", base + 1, 20);
    check_vec("rc_word", 32'(q_log[base]), 32'h154);

    // Empty-flag exit from a short burst, then rotation to channel 0
    tick(2);
    base = n_acc;
    push(3, 8'h31); push(3, 8'h32);
    k = 0;
    while (!fifo_rd_en[3] && k < 5) begin tick(1); k++; end
    check_vec("ef_rd3", 32'(fifo_rd_en), 32'h8);
    push(0, 8'h05);
    wait_acc("ef_cnt", base + 3, 40);
    check_vec("ef_w0", 32'(q_log[base]), 32'h331);
    check_vec("ef_w1", 32'(q_log[base + 1]), 32'h332);
    check_vec("ef_w2", 32'(q_log[base + 2]), 32'h005);
    tick(2);
    check_vec("ef_ptr", 32'(dut.r_rr_ptr), 32'd1);
    check_vec("ef_busy", 32'(busy), 32'd0);
    check_vec("ef_wcnt", 32'(word_count), 32'd4);
    check_vec("rd_on_empty", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
